// File: rtl/decoder_5b_4b_rx.sv
// decoder_5b_4b_rx: serial 4b/5b receive decoder with sync hunt, invalid-code detection and loss-of-lock; define DECODER_5B4B_ERRCNT_EN for the saturating err_count register
module decoder_5b_4b_rx #(
  parameter int         ERR_LIMIT = 3,
  parameter logic [4:0] SYNC_SYM  = 5'b11000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_bit,
  input  logic       rx_valid,
  output logic [3:0] out,
  output logic       out_valid,
  output logic       code_err,
  output logic       locked,
  output logic [7:0] err_count
);
  typedef enum logic {ST_HUNT, ST_LOCKED} state_t;
  state_t     state, state_nx;
  logic [4:0] sr, sr_nx;
  logic [2:0] bit_cnt, cnt_nx;
  logic [3:0] cons, cons_nx, out_nx, nib;
  logic       ov_nx, ce_nx, is_data;
  assign sr_nx  = {sr[3:0], rx_bit};
  assign locked = state == ST_LOCKED;
  always_comb begin
    is_data = 1'b1;
    nib     = 4'h0;
    case (sr_nx)
      5'b00100: nib = 4'h0;
      5'b00101: nib = 4'h1;
      5'b00110: nib = 4'h2;
      5'b01001: nib = 4'h3;
      5'b01010: nib = 4'h4;
      5'b01011: nib = 4'h5;
      5'b01100: nib = 4'h6;
      5'b01101: nib = 4'h7;
      5'b10010: nib = 4'h8;
      5'b10011: nib = 4'h9;
      5'b10100: nib = 4'hA;
      5'b10101: nib = 4'hB;
      5'b10110: nib = 4'hC;
      5'b11001: nib = 4'hD;
      5'b11010: nib = 4'hE;
      5'b11011: nib = 4'hF;
      default:  is_data = 1'b0;
    endcase
  end
  // symbols are classified on the post-shift word so outputs land on the 5th bit's edge
  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    cons_nx  = cons;
    out_nx   = out;
    ov_nx    = 1'b0;
    ce_nx    = 1'b0;
    if (rx_valid) begin
      if (state == ST_HUNT) begin
        if (sr_nx == SYNC_SYM) begin
          state_nx = ST_LOCKED;
          cnt_nx   = 3'd0;
        end
      end else if (bit_cnt == 3'd4) begin
        cnt_nx = 3'd0;
        if (is_data) begin
          out_nx  = nib;
          ov_nx   = 1'b1;
          cons_nx = 4'd0;
        end else if (sr_nx == SYNC_SYM) begin
          cons_nx = 4'd0;
        end else begin
          ce_nx    = 1'b1;
          cons_nx  = cons == 4'(ERR_LIMIT - 1) ? 4'd0 : cons + 4'd1;
          state_nx = cons == 4'(ERR_LIMIT - 1) ? ST_HUNT : ST_LOCKED;
        end
      end else begin
        cnt_nx = bit_cnt + 3'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HUNT;
      sr        <= 5'd0;
      bit_cnt   <= 3'd0;
      cons      <= 4'd0;
      out       <= 4'd0;
      out_valid <= 1'b0;
      code_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      sr        <= rx_valid ? sr_nx : sr;
      bit_cnt   <= cnt_nx;
      cons      <= cons_nx;
      out       <= out_nx;
      out_valid <= ov_nx;
      code_err  <= ce_nx;
    end
  end
`ifdef DECODER_5B4B_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count <= 8'd0;
    else if (ce_nx && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`else
  assign err_count = 8'd0;
`endif
endmodule
